// File: rtl/pwm_meter.sv
// pwm_meter: measures high time and period of an asynchronous PWM line,
// with stuck-high/stuck-low detection and sticky counter-overflow flag.
`default_nettype none

module pwm_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             clr,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic s1, s2, s3;
  logic rise, fall;

  state_t           state, state_nx;
  logic [CNT_W-1:0] hcnt, hcnt_nx;
  logic [CNT_W-1:0] pcnt, pcnt_nx;
  logic [CNT_W-1:0] idle_cnt, idle_nx;
  logic [CNT_W-1:0] high_nx, period_nx;
  logic             valid_nx, sh_nx, sl_nx, ovf_nx;

  // Synchroniser is deliberately untouched by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hcnt       <= '0;
      pcnt       <= '0;
      idle_cnt   <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      hcnt       <= hcnt_nx;
      pcnt       <= pcnt_nx;
      idle_cnt   <= idle_nx;
      high_cnt   <= high_nx;
      period_cnt <= period_nx;
      meas_valid <= valid_nx;
      stuck_high <= sh_nx;
      stuck_low  <= sl_nx;
      overflow   <= ovf_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    hcnt_nx   = hcnt;
    pcnt_nx   = pcnt;
    idle_nx   = idle_cnt;
    high_nx   = high_cnt;
    period_nx = period_cnt;
    valid_nx  = 1'b0;
    sh_nx     = stuck_high;
    sl_nx     = stuck_low;
    ovf_nx    = overflow;

    if (clr) begin
      state_nx  = IDLE;
      hcnt_nx   = '0;
      pcnt_nx   = '0;
      idle_nx   = '0;
      high_nx   = '0;
      period_nx = '0;
      sh_nx     = 1'b0;
      sl_nx     = 1'b0;
      ovf_nx    = 1'b0;
    end else begin
      // Idle counter parks at TO_VAL so a stuck line strobes only once.
      if (rise || fall) begin
        idle_nx = '0;
      end else if (idle_cnt != TO_VAL) begin
        idle_nx = idle_cnt + CNT_ONE;
      end

      if (rise) begin
        sh_nx = 1'b0;
        sl_nx = 1'b0;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state_nx = HIGH;
            hcnt_nx  = CNT_ONE;
            pcnt_nx  = CNT_ONE;
          end
        end
        HIGH: begin
          if (pcnt == CNT_MAX) ovf_nx = 1'b1;
          else                 pcnt_nx = pcnt + CNT_ONE;
          if (fall) begin
            state_nx = LOW;
          end else begin
            if (hcnt == CNT_MAX) ovf_nx = 1'b1;
            else                 hcnt_nx = hcnt + CNT_ONE;
          end
        end
        LOW: begin
          if (rise) begin
            high_nx   = hcnt;
            period_nx = pcnt;
            valid_nx  = 1'b1;
            hcnt_nx   = CNT_ONE;
            pcnt_nx   = CNT_ONE;
            state_nx  = HIGH;
          end else begin
            if (pcnt == CNT_MAX) ovf_nx = 1'b1;
            else                 pcnt_nx = pcnt + CNT_ONE;
          end
        end
        default: state_nx = IDLE;
      endcase

      // An edge clears the idle counter, so a timeout never coincides with one.
      if (!rise && !fall && idle_cnt == TO_M1) begin
        state_nx  = IDLE;
        hcnt_nx   = '0;
        pcnt_nx   = '0;
        sh_nx     = s2;
        sl_nx     = ~s2;
        high_nx   = s2 ? CNT_MAX : '0;
        period_nx = '0;
        valid_nx  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_meter.sv
// tb_pwm_meter: directed self-checking bench for pwm_meter (16-bit and 8-bit instances).
`default_nettype none

module tb_pwm_meter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pwm16 = 1'b0, clr16 = 1'b0;
  logic pwm8 = 1'b0, clr8 = 1'b0;

  logic [15:0] high16, period16;
  logic        valid16, sh16, sl16, ovf16;
  logic [7:0]  high8, period8;
  logic        valid8, sh8, sl8, ovf8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nval16 = 0;
  int last_cyc = 0;
  int prev_cyc = 0;

  always #10 clk = ~clk;

  pwm_meter #(.CNT_W(16), .TIMEOUT(1000)) u16 (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm16), .clr(clr16),
    .high_cnt(high16), .period_cnt(period16), .meas_valid(valid16),
    .stuck_high(sh16), .stuck_low(sl16), .overflow(ovf16)
  );

  pwm_meter #(.CNT_W(8), .TIMEOUT(250)) u8 (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm8), .clr(clr8),
    .high_cnt(high8), .period_cnt(period8), .meas_valid(valid8),
    .stuck_high(sh8), .stuck_low(sl8), .overflow(ovf8)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid16 === 1'b1) begin
      nval16++;
      prev_cyc = last_cyc;
      last_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero16(input string tag);
    chk({tag, "_high"}, {16'd0, high16}, 32'd0);
    chk({tag, "_period"}, {16'd0, period16}, 32'd0);
    chk({tag, "_flags"}, {27'd0, valid16, sh16, sl16, ovf16, 1'b0}, 32'd0);
  endtask

  // One PWM period on the 16-bit instance; the strobe for the previous
  // period lands on the third edge after the line goes high.
  task automatic period_chk(input int h, input int l, input logic exp_v,
                            input int exp_h, input int exp_p, input string tag);
    int n0;
    n0 = nval16;
    pwm16 = 1'b1;
    tick();
    tick();
    chk({tag, "_early"}, {31'd0, valid16}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, valid16}, {31'd0, exp_v});
    if (exp_v) begin
      chk({tag, "_high"}, {16'd0, high16}, exp_h);
      chk({tag, "_period"}, {16'd0, period16}, exp_p);
    end
    repeat (h - 3) tick();
    pwm16 = 1'b0;
    repeat (l) tick();
    chk({tag, "_nstrobe"}, nval16 - n0, {31'd0, exp_v});
  endtask

  initial begin
    int n0;
    #5 rst_n = 1'b0;
    #1;
    chk_all_zero16("reset_assert");
    chk("reset_u8", {23'd0, high8, ovf8}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk_all_zero16("reset_release");
    chk("reset_nstrobe", nval16, 0);

    // Steady 30/100
    period_chk(30, 70, 1'b0, 0, 0, "first_rise");
    period_chk(30, 70, 1'b1, 30, 100, "steady1");
    period_chk(30, 70, 1'b1, 30, 100, "steady2");
    period_chk(30, 70, 1'b1, 30, 100, "steady3");
    chk("steady_spacing", last_cyc - prev_cyc, 100);

    // Duty step at a period boundary
    period_chk(31, 69, 1'b1, 30, 100, "step_old");
    period_chk(31, 69, 1'b1, 31, 100, "step_new");

    // Line stuck low
    n0 = nval16;
    pwm16 = 1'b1;
    repeat (3) tick();
    chk("sl_lastmeas", {16'd0, high16}, 31);
    repeat (28) tick();
    pwm16 = 1'b0;
    repeat (1002) tick();
    chk("sl_before", {30'd0, valid16, sl16}, 32'd0);
    tick();
    chk("sl_valid", {31'd0, valid16}, 32'd1);
    chk("sl_flag", {30'd0, sh16, sl16}, 32'd1);
    chk("sl_high", {16'd0, high16}, 32'd0);
    chk("sl_period", {16'd0, period16}, 32'd0);
    repeat (197) tick();
    chk("sl_single", nval16 - n0, 2);
    chk("sl_hold", {31'd0, sl16}, 32'd1);
    period_chk(30, 70, 1'b0, 0, 0, "sl_resume1");
    chk("sl_cleared", {31'd0, sl16}, 32'd0);
    period_chk(30, 70, 1'b1, 30, 100, "sl_resume2");

    // Line stuck high
    pwm16 = 1'b1;
    repeat (3) tick();
    chk("sh_lastmeas", {16'd0, period16}, 100);
    repeat (999) tick();
    chk("sh_before", {30'd0, valid16, sh16}, 32'd0);
    tick();
    chk("sh_valid", {31'd0, valid16}, 32'd1);
    chk("sh_flag", {30'd0, sh16, sl16}, 32'd2);
    chk("sh_high", {16'd0, high16}, 32'h0000_FFFF);
    chk("sh_period", {16'd0, period16}, 32'd0);
    repeat (20) tick();
    pwm16 = 1'b0;
    repeat (70) tick();
    chk("sh_after_fall", {31'd0, sh16}, 32'd1);
    period_chk(30, 70, 1'b0, 0, 0, "sh_resume1");
    chk("sh_cleared", {31'd0, sh16}, 32'd0);
    period_chk(30, 70, 1'b1, 30, 100, "sh_resume2");

    // Clear mid-HIGH, then clear coincident with a rise
    pwm16 = 1'b1;
    repeat (3) tick();
    chk("clr_pre", {16'd0, high16}, 30);
    repeat (5) tick();
    clr16 = 1'b1;
    tick();
    clr16 = 1'b0;
    chk_all_zero16("clr_mid");
    repeat (21) tick();
    pwm16 = 1'b0;
    repeat (70) tick();
    n0 = nval16;
    pwm16 = 1'b1;
    tick();
    tick();
    clr16 = 1'b1;
    tick();
    clr16 = 1'b0;
    chk_all_zero16("clr_rise");
    repeat (27) tick();
    pwm16 = 1'b0;
    repeat (70) tick();
    period_chk(30, 70, 1'b0, 0, 0, "clr_resume1");
    chk("clr_nostrobe", nval16 - n0, 0);
    period_chk(30, 70, 1'b1, 30, 100, "clr_resume2");

    // Asynchronous reset mid-stream
    pwm16 = 1'b1;
    repeat (3) tick();
    chk("rst_pre", {31'd0, valid16}, 32'd1);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero16("rst_mid");
    pwm16 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    n0 = nval16;
    repeat (10) tick();
    chk_all_zero16("rst_mid_release");
    chk("rst_nostrobe", nval16 - n0, 0);

    // Overflow on the 8-bit instance
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    chk("ovf_clr0", {31'd0, ovf8}, 32'd0);
    pwm8 = 1'b1;
    repeat (200) tick();
    pwm8 = 1'b0;
    repeat (200) tick();
    pwm8 = 1'b1;
    repeat (3) tick();
    chk("ovf_valid", {31'd0, valid8}, 32'd1);
    chk("ovf_high", {24'd0, high8}, 200);
    chk("ovf_period", {24'd0, period8}, 255);
    chk("ovf_flag", {31'd0, ovf8}, 32'd1);
    repeat (197) tick();
    pwm8 = 1'b0;
    repeat (200) tick();
    pwm8 = 1'b1;
    repeat (3) tick();
    chk("ovf_sticky", {31'd0, ovf8}, 32'd1);
    chk("ovf_period2", {24'd0, period8}, 255);
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    chk("ovf_cleared", {31'd0, ovf8}, 32'd0);
    chk("ovf_clr_high", {24'd0, high8}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
